// File: rtl/axi3_master_pkg.sv
// axi3_master_pkg: AXI response/burst codes shared with the slave bridge, FSM encodings and the 4 KB check.
package axi3_master_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } axi_burst_e;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RADDR  = 3'd1;
  localparam logic [2:0] S_RDATA  = 3'd2;
  localparam logic [2:0] S_WADDR  = 3'd3;
  localparam logic [2:0] S_WDATA  = 3'd4;
  localparam logic [2:0] S_WRESP  = 3'd5;
  localparam logic [2:0] S_REJECT = 3'd6;

  // AXI forbids an INCR burst from crossing a 4 KB page; word is addr[11:2]
  function automatic logic crosses_4k(input logic [9:0] word, input logic [3:0] len);
    return ({1'b0, word} + {7'd0, len}) > 11'd1023;
  endfunction

endpackage

// File: rtl/axi3_master_if.sv
// axi3_master_if: AXI3 address/data/response channels between the bridge and an AXI3 slave port.
interface axi3_master_if #(parameter int IDW = 6);
  logic           arvalid, arready;
  logic [31:0]    araddr;
  logic [3:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic [IDW-1:0] arid;
  logic [1:0]     arlock;
  logic [3:0]     arcache;
  logic [2:0]     arprot;
  logic [3:0]     arqos;
  logic           rvalid, rready, rlast;
  logic [31:0]    rdata;
  logic [1:0]     rresp;
  logic [IDW-1:0] rid;
  logic           awvalid, awready;
  logic [31:0]    awaddr;
  logic [3:0]     awlen;
  logic [2:0]     awsize;
  logic [1:0]     awburst;
  logic [IDW-1:0] awid;
  logic [1:0]     awlock;
  logic [3:0]     awcache;
  logic [2:0]     awprot;
  logic [3:0]     awqos;
  logic           wvalid, wready, wlast;
  logic [31:0]    wdata;
  logic [3:0]     wstrb;
  logic [IDW-1:0] wid;
  logic           bvalid, bready;
  logic [1:0]     bresp;
  logic [IDW-1:0] bid;

  modport master(
    output arvalid, araddr, arlen, arsize, arburst, arid, arlock, arcache, arprot, arqos,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready,
    output awvalid, awaddr, awlen, awsize, awburst, awid, awlock, awcache, awprot, awqos,
    input  awready,
    output wvalid, wdata, wstrb, wlast, wid,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

  modport slave(
    input  arvalid, araddr, arlen, arsize, arburst, arid, arlock, arcache, arprot, arqos,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready,
    input  awvalid, awaddr, awlen, awsize, awburst, awid, awlock, awcache, awprot, awqos,
    output awready,
    input  wvalid, wdata, wstrb, wlast, wid,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );
endinterface

// File: rtl/axi3_master.sv
// axi3_master: local req/ack bus to AXI3 INCR burst master, one transaction outstanding.
module axi3_master
  import axi3_master_pkg::*;
#(
  parameter int IDW  = 6,
  parameter int TXID = 0
) (
  input  logic          clk,
  input  logic          rstn,
  output logic          axiaclk,
  input  logic          reqvalid,
  output logic          reqready,
  input  logic          reqwr,
  input  logic [31:0]   reqaddr,
  input  logic [3:0]    reqlen,
  input  logic          wdvalid,
  output logic          wdready,
  input  logic [31:0]   wddata,
  input  logic [3:0]    wdstrb,
  output logic          rdvalid,
  output logic [31:0]   rddata,
  output logic          done,
  output logic          err,
  axi3_master_if.master axi
);

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        acc_q, acc_d;
  logic        arvalid_q, arvalid_d;
  logic        awvalid_q, awvalid_d;
  logic        rready_q, rready_d;
  logic        bready_q, bready_d;
  logic        rdvalid_q, rdvalid_d;
  logic [31:0] rddata_q, rddata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        reqready_q, reqready_d;
  logic        wsel, rej;

  assign wsel = state_q == S_WDATA;
  assign rej  = crosses_4k(reqaddr[11:2], reqlen);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    arvalid_d  = arvalid_q;
    awvalid_d  = awvalid_q;
    rready_d   = rready_q;
    bready_d   = bready_q;
    rddata_d   = rddata_q;
    reqready_d = reqready_q;
    rdvalid_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: if (reqvalid) begin
        addr_d     = reqaddr & ~32'h3;
        len_d      = reqlen;
        acc_d      = 1'b0;
        reqready_d = 1'b0;
        arvalid_d  = !rej && !reqwr;
        awvalid_d  = !rej && reqwr;
        state_d    = rej ? S_REJECT : reqwr ? S_WADDR : S_RADDR;
      end
      S_RADDR: if (axi.arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = S_RDATA;
      end
      S_RDATA: if (axi.rvalid && rready_q) begin
        rdvalid_d = 1'b1;
        rddata_d  = axi.rdata;
        acc_d     = acc_q | (axi.rresp != OKAY);
        if (axi.rlast) begin
          rready_d   = 1'b0;
          done_d     = 1'b1;
          err_d      = acc_d;
          reqready_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_WADDR: if (axi.awready) begin
        awvalid_d = 1'b0;
        cnt_d     = len_q;
        state_d   = S_WDATA;
      end
      S_WDATA: if (wdvalid && axi.wready) begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end
      S_WRESP: if (axi.bvalid && bready_q) begin
        bready_d   = 1'b0;
        done_d     = 1'b1;
        err_d      = axi.bresp != OKAY;
        reqready_d = 1'b1;
        state_d    = S_IDLE;
      end
      S_REJECT: begin
        done_d     = 1'b1;
        err_d      = 1'b1;
        reqready_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= 1'b0;
      arvalid_q  <= 1'b0;
      awvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      bready_q   <= 1'b0;
      rdvalid_q  <= 1'b0;
      rddata_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      reqready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      arvalid_q  <= arvalid_d;
      awvalid_q  <= awvalid_d;
      rready_q   <= rready_d;
      bready_q   <= bready_d;
      rdvalid_q  <= rdvalid_d;
      rddata_q   <= rddata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      reqready_q <= reqready_d;
    end
  end

  assign axiaclk  = clk;
  assign reqready = reqready_q;
  assign rdvalid  = rdvalid_q;
  assign rddata   = rddata_q;
  assign done     = done_q;
  assign err      = err_q;

  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = 3'd2;
  assign axi.arburst = INCR;
  assign axi.arid    = IDW'(TXID);
  assign axi.arlock  = 2'd0;
  assign axi.arcache = 4'd3;
  assign axi.arprot  = 3'd0;
  assign axi.arqos   = 4'd0;
  assign axi.rready  = rready_q;

  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = len_q;
  assign axi.awsize  = 3'd2;
  assign axi.awburst = INCR;
  assign axi.awid    = IDW'(TXID);
  assign axi.awlock  = 2'd0;
  assign axi.awcache = 4'd3;
  assign axi.awprot  = 3'd0;
  assign axi.awqos   = 4'd0;

  // W is a straight pass-through of the local write port, opened only after AW completes
  assign axi.wvalid = wsel && wdvalid;
  assign wdready    = wsel && axi.wready;
  assign axi.wdata  = wddata;
  assign axi.wstrb  = wdstrb;
  assign axi.wlast  = wsel && (cnt_q == 4'd0);
  assign axi.wid    = IDW'(TXID);
  assign axi.bready = bready_q;

endmodule

// File: tb/tb_axi3_master.sv
// tb_axi3_master: randomized bursts against a page-based reference model and a behavioural AXI3 slave.
module tb_axi3_master;
  import axi3_master_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        axiaclk, reqvalid, reqready, reqwr;
  logic [31:0] reqaddr;
  logic [3:0]  reqlen;
  logic        wdvalid, wdready;
  logic [31:0] wddata;
  logic [3:0]  wdstrb;
  logic        rdvalid, done, err;
  logic [31:0] rddata;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  axi3_master_if #(.IDW(6)) axi();

  axi3_master #(.IDW(6), .TXID(0)) dut (
    .clk(clk), .rstn(rstn), .axiaclk(axiaclk),
    .reqvalid(reqvalid), .reqready(reqready), .reqwr(reqwr), .reqaddr(reqaddr), .reqlen(reqlen),
    .wdvalid(wdvalid), .wdready(wdready), .wddata(wddata), .wdstrb(wdstrb),
    .rdvalid(rdvalid), .rddata(rddata), .done(done), .err(err), .axi(axi)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reqvalid = 0; wdvalid = 0; wddata = 0; wdstrb = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0; axi.rid = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.bid = 0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_arvalid"}, axi.arvalid, 0);
    check({tag, "_awvalid"}, axi.awvalid, 0);
    check({tag, "_rready"}, axi.rready, 0);
    check({tag, "_bready"}, axi.bready, 0);
    check({tag, "_rdvalid"}, rdvalid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_reqready"}, reqready, 1);
  endtask

  // bad: beat index answered DECERR on reads, or any value >=0 gives SLVERR on writes
  task automatic txn(input bit wr, input logic [31:0] a, input logic [3:0] l, input bit bp,
                     input int bad, input logic [31:0] d0, input int aw_delay, input bit abort);
    logic [31:0] ea, cur_d;
    logic [31:0] wd[16];
    logic [3:0]  ws[16];
    logic [31:0] q[$];
    logic [1:0]  cur_r;
    bit          rej, exp_err, ar_ok, aw_ok, b_ok, fin;
    int          li, ri, wi, nrd, cyc, aw_wait;
    ea = a & 32'hFFFF_FFFC;
    li = int'(l);
    rej = (ea >> 12) != ((ea + 32'(li) * 4) >> 12);
    exp_err = rej || (bad >= 0 && (wr || bad <= li));
    for (int i = 0; i < 16; i++) begin
      wd[i] = d0 + 32'(i);
      ws[i] = 4'($urandom);
    end
    cur_d = d0;
    cur_r = (bad == 0) ? DECERR : OKAY;
    ar_ok = 0; aw_ok = 0; b_ok = 0; fin = 0;
    ri = 0; wi = 0; nrd = 0; cyc = 0; aw_wait = 0;
    @(negedge clk);
    reqvalid = 1; reqwr = wr; reqaddr = a; reqlen = l;
    #1 check("reqready", reqready, 1);
    @(negedge clk);
    reqvalid = 0; reqaddr = $urandom; reqlen = 4'($urandom);
    while (!fin && cyc < 300) begin
      if (err && !done) check("err_no_done", err, 0);
      if (rdvalid) begin
        nrd++;
        if (q.size() > 0) check("rddata", rddata, q.pop_front());
        else check("rdvalid_extra", rdvalid, 0);
      end
      if (rej) check("rej_axi", axi.arvalid | axi.awvalid, 0);
      if (axi.arvalid) begin
        check("araddr", axi.araddr, ea);
        check("arlen", axi.arlen, l);
      end
      if (axi.awvalid) begin
        check("awaddr", axi.awaddr, ea);
        check("awlen", axi.awlen, l);
      end
      if (axi.wvalid && !aw_ok) check("w_before_aw", axi.wvalid, 0);
      if (done) begin
        fin = 1;
        check("err", err, exp_err);
        check("reqready_done", reqready, 1);
        if (rej) check("rej_latency", cyc <= 2, 1);
        else if (wr) begin
          check("wbeats", wi, li + 1);
          check("b_before_done", b_ok, 1);
        end else check("rbeats", nrd, li + 1);
      end
      if (!fin) begin
        if (axi.awvalid) aw_wait++;
        axi.arready = bp ? 1'($urandom % 2) : 1'b1;
        axi.awready = (aw_wait > aw_delay) && (bp ? 1'($urandom % 2) : 1'b1);
        axi.rvalid  = ar_ok && ri <= li && (bp ? ($urandom % 3 != 0) : 1'b1);
        axi.rdata   = cur_d;
        axi.rresp   = cur_r;
        axi.rlast   = ri == li;
        wdvalid     = wi <= li && (bp ? 1'($urandom % 2) : 1'b1);
        wddata      = wi < 16 ? wd[wi] : 32'd0;
        wdstrb      = wi < 16 ? ws[wi] : 4'd0;
        axi.wready  = bp ? 1'($urandom % 2) : 1'b1;
        axi.bvalid  = wi > li && !b_ok;
        axi.bresp   = bad >= 0 ? SLVERR : OKAY;
        #1;
        if (axi.arvalid && axi.arready) begin
          check("arsize", axi.arsize, 2);
          check("arburst", axi.arburst, INCR);
          check("arcache", axi.arcache, 3);
          check("arid", axi.arid, 0);
          ar_ok = 1;
        end
        if (axi.rvalid && axi.rready) begin
          q.push_back(cur_d);
          ri++;
          cur_d = $urandom;
          cur_r = (ri == bad) ? DECERR : OKAY;
        end
        if (axi.awvalid && axi.awready) begin
          check("awburst", axi.awburst, INCR);
          check("aw_delay", aw_wait > aw_delay, 1);
          aw_ok = 1;
        end
        if (axi.wvalid && axi.wready) begin
          check("wdata", axi.wdata, wd[wi]);
          check("wstrb", axi.wstrb, ws[wi]);
          check("wlast", axi.wlast, wi == li);
          check("wdready", wdready, 1);
          wi++;
        end
        if (axi.bvalid && axi.bready) b_ok = 1;
        if (abort && ri == 3) begin
          rstn = 0;
          #1 check_quiet("reset_async");
          idle();
          @(negedge clk);
          rstn = 1;
          return;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check("done_seen", fin, 1);
    idle();
  endtask

  initial begin
    idle();
    reqwr = 0; reqaddr = 0; reqlen = 0;
    #2 rstn = 0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("axiaclk", axiaclk, clk);
    rstn = 1;
    txn(0, 32'h1000_0007, 4'd0, 0, -1, 32'hDEAD_BEEF, 0, 0);
    txn(1, 32'h2000_0100, 4'd3, 0, -1, 32'd1, 3, 0);
    txn(1, 32'h2000_0200, 4'd2, 0, 0, 32'h55, 0, 0);
    txn(0, 32'h3000_0000, 4'd15, 0, 2, 32'h77, 0, 0);
    txn(0, 32'h0000_0FF0, 4'd4, 0, -1, 32'h1, 0, 0);
    txn(1, 32'h0000_0FF0, 4'd4, 0, -1, 32'h1, 0, 0);
    txn(0, 32'h0000_0FF0, 4'd3, 0, -1, 32'h9, 0, 0);
    txn(1, 32'h0000_0FF0, 4'd3, 0, -1, 32'h9, 0, 0);
    txn(1, 32'h4000_0000, 4'd15, 1, -1, 32'hA000, 1, 0);
    txn(0, 32'h4000_0400, 4'd15, 1, -1, 32'hB000, 0, 0);
    txn(0, 32'h5000_0000, 4'd15, 0, -1, 32'hC000, 0, 1);
    check_quiet("after_reset");
    txn(0, 32'h5000_0040, 4'd5, 0, -1, 32'hD000, 0, 0);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom % 3 == 0) a = (a & 32'hFFFF_F000) | (32'hFC0 + ($urandom % 64));
      txn(1'($urandom), a, 4'($urandom), 1'($urandom), ($urandom % 4 == 0) ? int'($urandom % 16) : -1,
          $urandom, int'($urandom % 3), 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axi3_master.md
Name: axi3_master

Overview:
- Local-bus-to-AXI3 master bridge: accepts simple read/write burst requests from fabric logic and issues them as AXI3 INCR bursts on a 32-bit AXI3 slave port (e.g. Zynq S_AXI_HP/GP).
- It is the complement of the existing AXI3-slave-to-req/ack bridge: that block serves AXI transactions, this one initiates them.
- One transaction outstanding at a time, with in-order completion.

Parameters:
- IDW, 6, AXI ID width.
- TXID, 0, constant ID driven on axiarid/axiawid/axiwid.

Ports:
- clk  in  1  sole clock.
- rstn  in  1  reset; asynchronous, active-low.
- axiaclk  out  1  = clk.
- reqvalid / reqready  in / out  1 / 1  request handshake.
- reqwr  in  1  1 = write.
- reqaddr  in  32  byte address; bits [1:0] ignored.
- reqlen  in  4  beats-1 (0..15).
- wdvalid / wdready  in / out  1 / 1  write-data handshake.
- wddata / wdstrb  in  32 / 4  write beat and byte strobes.
- rdvalid  out  1  one-cycle read-beat strobe; no backpressure.
- rddata  out  32  read beat.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = any non-OKAY response or rejected request.
- axiarvalid / axiarready  out / in; axiaraddr out 32; axiarlen out 4; axiarsize out 3 (=2); axiarburst out 2 (=INCR); axiarid out IDW.
- axiarlock / axiarcache / axiarprot / axiarqos  out  2/4/3/4  constants 0/3/0/0.
- axirvalid in; axirready out; axirdata in 32; axirresp in 2; axirlast in; axirid in IDW (ignored).
- axiawvalid / axiawready, axiawaddr, axiawlen, axiawsize, axiawburst, axiawid, axiawlock/cache/prot/qos: same as the AR channel.
- axiwvalid / axiwready  out / in; axiwdata out 32; axiwstrb out 4; axiwlast out; axiwid out IDW.
- axibvalid in; axibready out; axibresp in 2; axibid in IDW (ignored).

Behaviour:
- Reset (async, rstn low): state=IDLE. reqready=1. All AXI valids, axirready, axibready, rdvalid, done, err = 0. Address, data and length registers are don't-care. Reset mid-burst abandons the transaction immediately; the AXI side is assumed to be reset together.
- States:
  - IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, REJECT.
  - reqready=1 only in IDLE.
- IDLE, on reqvalid:
  - Latch addr (low 2 bits forced to 0), len, wr. reqready<=0. Clear resp accumulator.
  - 4 KB check: if {1'b0,addr[11:2]}+len > 1023, go to REJECT. No AXI traffic is issued.
  - Otherwise go to WADDR (awvalid<=1) or RADDR (arvalid<=1). AXI address/len are driven the following cycle.
- RADDR: hold arvalid and fields stable until arready. Then arvalid<=0, axirready<=1, go to RDATA.
- RDATA:
  - Each rvalid&&rready beat: rdvalid<=1, rddata<=rdata (1-cycle latency). Accumulate err |= (rresp!=OKAY).
  - On the beat with rlast: axirready<=0, done<=1, err<=accumulated, reqready<=1, go to IDLE.
  - rlast arriving earlier or later than len is not checked; rlast alone terminates the burst.
- WADDR: hold awvalid until awready, then go to WDATA. The beat counter is loaded with len.
- WDATA:
  - Combinational pass-through: axiwvalid=wdvalid, wdready=axiwready, axiwdata=wddata, axiwstrb=wdstrb, axiwlast=(count==0). W data is never presented before AW completes.
  - Each wvalid&&wready decrements count.
  - On the last beat: axibready<=1, go to WRESP.
- WRESP: on bvalid: axibready<=0, done<=1, err<=(bresp!=OKAY), reqready<=1, go to IDLE.
- REJECT: one cycle; done<=1, err<=1, reqready<=1, go to IDLE.
- done, err and rdvalid are single-cycle pulses. err is low whenever done is low.
- A back-to-back request is accepted the cycle after done: reqready is high in the same cycle done is high.
- The RDATA→IDLE, WRESP→IDLE and REJECT→IDLE transitions set reqready<=1 in the same cycle as done<=1.
- AXI valid/ready outputs never drop before their handshake completes.

Decomposition:
- Shared package/header: AXI response codes (OKAY/EXOKAY/SLVERR/DECERR), burst codes (FIXED/INCR/WRAP), state encodings. The response and burst codes are shared with the existing slave bridge.
- No sub-module needed: single FSM plus beat counter. The 4 KB check is a small function.

Test Plan:
- Single read: reqaddr=0x1000_0007, len=0; slave returns rdata=0xDEADBEEF, OKAY, rlast → araddr=0x1000_0004, arlen=0; rdvalid with 0xDEADBEEF; done=1, err=0.
- 4-beat write, awready delayed 3 cycles: wdata 1..4 → AW held stable; W beats only after AW; wlast on 4th beat only; done after bvalid; err=0.
- Write with bresp=SLVERR, and read burst with beat 2 rresp=DECERR → done=1, err=1 in both cases; all 16 read beats are still delivered.
- 4 KB crossing: reqaddr=0x0000_0FF0, len=4 → done, err=1 within 2 cycles; no arvalid/awvalid ever asserted. The same request with len=3 is accepted normally.
- Backpressure: wdvalid toggled, axiwready random, rvalid gaps → beat count exact, no data loss, rdvalid count = 16 for len=15.
- Reset asserted mid-RDATA → all valids/readys low asynchronously, reqready=1 after release, next request completes normally.
